// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_pkg
// Description : Shared constants and fetch FSM encoding for the fetch/decode path.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO with push/pop/flush, occupancy count and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage is not reset; readers qualify the head with empty.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC owner, single-outstanding imem fetcher and 2-entry decode queue.
//               IFETCH_MISALIGN_TRAP_EN adds a sticky misaligned-redirect halt.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int                 c_cnt_w  = $clog2(QDEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_qdepth = c_cnt_w'(QDEPTH);

  fetch_state_t      r_state, w_state_nxt;
  logic [XLEN-1:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [XLEN-1:0]   r_req_pc, w_req_pc_nxt;
  logic [XLEN-1:0]   w_redirect_pc;
  logic              w_redirect_trap;
  logic              w_halt_busy;
  logic              w_outstanding;
  logic              w_req_valid;

  logic              w_q_push, w_q_pop, w_q_flush;
  logic [2*XLEN-1:0] w_q_head;
  logic [c_cnt_w-1:0] w_q_count;
  logic              w_q_full, w_q_empty;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic r_misalign, r_halt_pend;

  assign w_redirect_pc   = redirect_pc;
  assign w_redirect_trap = (redirect_pc[1:0] != 2'b00);
  assign w_halt_busy     = r_halt_pend;

  // A request still in flight when halting must be drained before fetching again.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign  <= 1'b0;
      r_halt_pend <= 1'b0;
    end else if (redirect_valid) begin
      r_misalign  <= w_redirect_trap;
      r_halt_pend <= w_redirect_trap && w_outstanding;
    end else if (r_state == ST_HALT) begin
      r_halt_pend <= r_halt_pend && !imem_rsp_valid;
    end
  end

  assign fetch_misalign = r_misalign;
`else
  assign w_redirect_pc   = {redirect_pc[XLEN-1:2], redirect_pc[1:0] & 2'b00};
  assign w_redirect_trap = 1'b0;
  assign w_halt_busy     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_req_valid    = 1'b0;
    w_q_push       = 1'b0;
    w_q_pop        = 1'b0;
    w_q_flush      = 1'b0;
    // True when a response is still owed to us after this cycle.
    w_outstanding  = ((r_state == ST_WAIT) || (r_state == ST_DROP) ||
                      ((r_state == ST_HALT) && w_halt_busy)) && !imem_rsp_valid;

    if (redirect_valid) begin
      w_q_flush      = 1'b1;
      w_fetch_pc_nxt = w_redirect_pc;
      if (w_redirect_trap) begin
        w_state_nxt = ST_HALT;
      end else if (w_outstanding) begin
        w_state_nxt = ST_DROP;
      end else begin
        w_state_nxt = ST_FETCH;
      end
    end else begin
      w_q_pop = !w_q_empty && inst_ready;
      case (r_state)
        ST_FETCH: begin
          w_req_valid = (w_q_count < c_qdepth);
          if (w_req_valid && imem_req_ready) begin
            w_req_pc_nxt   = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            w_state_nxt    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            w_q_push    = !w_q_full;
            w_state_nxt = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (imem_rsp_valid) begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_HALT: begin
          w_state_nxt = ST_HALT;
        end
        default: begin
          w_state_nxt = ST_FETCH;
        end
      endcase
    end
  end

  fetch_queue #(
    .WIDTH (2*XLEN),
    .DEPTH (QDEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (w_q_push),
    .push_data ({imem_rsp_data, r_req_pc}),
    .pop       (w_q_pop),
    .flush     (w_q_flush),
    .head      (w_q_head),
    .count     (w_q_count),
    .full      (w_q_full),
    .empty     (w_q_empty)
  );

  assign imem_req_valid = w_req_valid && !reset;
  assign imem_req_addr  = r_fetch_pc;
  assign inst_valid     = !w_q_empty && !reset;
  assign inst           = inst_valid ? w_q_head[2*XLEN-1:XLEN] : '0;
  assign inst_pc        = inst_valid ? w_q_head[XLEN-1:0] : '0;

endmodule
`default_nettype wire
